// File: rtl/mib_training_rx.sv
// mib_training_rx: receive-side checker for the 13-bit MIB training bus.
// It aligns to the repeating 7-word training pattern, declares lock, and then
// counts word errors and checks that the training strobe toggles every cycle.
// Optional build macro MIB_BIT_ERR_EN adds the o_bit_err per-bit error mask.
//
// state  | meaning
// SEARCH | hunting for the 0x0AAA head word
// VERIFY | following the pattern, counting consecutive good words
// LOCKED | aligned; idx flywheels, mismatches are counted
module mib_training_rx #(
  parameter int LOCK_COUNT = 14,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [12:0]      i_mib_ad,
  input  logic             i_mib,
  input  logic             i_clr_err,
  output logic             o_locked,
  output logic [2:0]       o_word_idx,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic             o_toggle_err
`ifdef MIB_BIT_ERR_EN
  ,
  output logic [12:0]      o_bit_err
`endif
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(LOSS_COUNT + 1);
  // good_cnt value whose next match completes the lock run
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  LOSS_LAST = BAD_W'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [12:0] HEAD_WORD = 13'h0AAA;

  function automatic logic [12:0] pattern(input logic [2:0] sel);
    logic [12:0] w;
    case (sel)
      3'd0:    w = 13'h0AAA;
      3'd1:    w = 13'h0555;
      3'd2:    w = 13'h0F0F;
      3'd3:    w = 13'h10F0;
      3'd4:    w = 13'h0000;
      3'd5:    w = 13'h1FFF;
      3'd6:    w = 13'h00F5;
      default: w = 13'h0AAA;
    endcase
    return w;
  endfunction

  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt, idx_inc;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [BAD_W-1:0]  bad_cnt, bad_nxt;

  logic [12:0]       ad_q;
  logic              mib_q, mib_prev;
  logic [12:0]       exp_word;
  logic              match, is_head;
  logic              word_err, tog_fail;

  assign exp_word = pattern(idx);
  assign match    = (ad_q == exp_word);
  assign is_head  = (ad_q == HEAD_WORD);
  assign idx_inc  = (idx == 3'd6) ? 3'd0 : idx + 3'd1;

  // input capture stage; mib_prev holds the strobe one cycle older for the toggle check
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ad_q     <= '0;
      mib_q    <= 1'b0;
      mib_prev <= 1'b0;
    end else begin
      ad_q     <= i_mib_ad;
      mib_q    <= i_mib;
      mib_prev <= mib_q;
    end
  end

  // FSM state and alignment counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= SEARCH;
      idx      <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  // next-state: search for head, verify the run, flywheel once locked
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    case (state)
      SEARCH: begin
        if (is_head) begin
          state_nxt = VERIFY;
          idx_nxt   = 3'd1;
          good_nxt  = GOOD_W'(1);
        end
      end
      VERIFY: begin
        if (match) begin
          idx_nxt  = idx_inc;
          good_nxt = good_cnt + GOOD_W'(1);
          if (good_cnt == LOCK_LAST) state_nxt = LOCKED;
        end else if (is_head) begin
          // a stray head word restarts the run rather than dropping to search
          idx_nxt  = 3'd1;
          good_nxt = GOOD_W'(1);
        end else begin
          state_nxt = SEARCH;
          idx_nxt   = 3'd0;
          good_nxt  = '0;
        end
      end
      LOCKED: begin
        idx_nxt = idx_inc;
        if (match) begin
          bad_nxt = '0;
        end else if (bad_cnt == LOSS_LAST) begin
          state_nxt = SEARCH;
          idx_nxt   = 3'd0;
          good_nxt  = '0;
          bad_nxt   = '0;
        end else begin
          bad_nxt = bad_cnt + BAD_W'(1);
        end
      end
      default: begin
        state_nxt = SEARCH;
        idx_nxt   = 3'd0;
        good_nxt  = '0;
        bad_nxt   = '0;
      end
    endcase
  end

  // outputs and error qualifiers decoded from the current state
  always_comb begin
    o_locked   = (state == LOCKED);
    o_word_idx = idx;
    word_err   = (state == LOCKED) && !match;
    tog_fail   = (state == LOCKED) && (mib_q == mib_prev);
  end

  // error pulse, saturating counter and sticky toggle flag; clear wins over a same-cycle error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_pulse  <= 1'b0;
      o_err_cnt    <= '0;
      o_toggle_err <= 1'b0;
    end else begin
      o_err_pulse <= word_err;
      if (i_clr_err) begin
        o_err_cnt    <= '0;
        o_toggle_err <= 1'b0;
      end else begin
        if (word_err && (o_err_cnt != '1)) o_err_cnt <= o_err_cnt + ERR_W'(1);
        if (tog_fail) o_toggle_err <= 1'b1;
      end
    end
  end

`ifdef MIB_BIT_ERR_EN
  // accumulate the bit positions that have ever mismatched while locked
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bit_err <= '0;
    end else if (i_clr_err) begin
      o_bit_err <= '0;
    end else if (word_err) begin
      o_bit_err <= o_bit_err | (ad_q ^ exp_word);
    end
  end
`endif

endmodule
